lsu_controller: RTL and testbench

Multi-cycle load/store sequencer between the CPU control/datapath and the data-memory bus. It accepts one decoded load or store (func3, ALU effective address, rs2 data) and drives a req/ack memory bus with byte enables. It stalls the CPU until the access completes, then returns an aligned, sign- or zero-extended load result for register writeback.

---
 rtl/lsu_controller.sv | 173 +++++++++++++++++
 tb/tb_lsu_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
`default_nettype none
// lsu_controller: multi-cycle load/store sequencer driving a req/ack data bus with byte enables.
// Optional macro LSU_TIMEOUT_EN aborts an access after TIMEOUT_CYC BUSY cycles without ack.
module lsu_controller #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        func3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata_in,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata_out,
   output logic              misalign,
   output logic              err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic              r_is_store;
   logic [2:0]        r_func3;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_be;
   logic [31:0]       r_bus_wdata;
   logic [31:0]       r_rdata;
   logic              r_misalign;

   logic              w_illegal;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_shift;
   logic [31:0]       w_load;
   logic              w_timeout;

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = wdata_in;
      case (func3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata_in[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << addr[1:0];
            w_wdata = {2{wdata_in[15:0]}};
         end
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // Stores have no unsigned variants, so func3[2] set on a store is illegal.
   always_comb begin
      case (func3)
         3'b000, 3'b100: w_illegal = is_store & func3[2];
         3'b001, 3'b101: w_illegal = addr[0] | (is_store & func3[2]);
         3'b010:         w_illegal = |addr[1:0];
         default:        w_illegal = 1'b1;
      endcase
   end

   assign w_shift = bus_rdata >> {r_off, 3'b000};

   always_comb begin
      case (r_func3)
         3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b100:  w_load = {24'h0, w_shift[7:0]};
         3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b101:  w_load = {16'h0, w_shift[15:0]};
         default: w_load = w_shift;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_is_store  <= 1'b0;
         r_func3     <= 3'b000;
         r_off       <= 2'b00;
         r_bus_addr  <= '0;
         r_bus_be    <= 4'b0000;
         r_bus_wdata <= 32'h0;
         r_rdata     <= 32'h0;
         r_misalign  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_store  <= is_store;
                  r_func3     <= func3;
                  r_off       <= addr[1:0];
                  r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  r_bus_be    <= w_be;
                  r_bus_wdata <= w_wdata;
                  r_rdata     <= 32'h0;
                  r_misalign  <= w_illegal;
                  r_state     <= w_illegal ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus_ack) begin
                  r_rdata <= r_is_store ? 32'h0 : w_load;
                  r_state <= S_DONE;
               end else if (w_timeout) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_misalign <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state != S_BUSY)
            r_cnt <= '0;
         else if (!bus_ack)
            r_cnt <= r_cnt + 1'b1;
         if (w_timeout)
            r_err <= 1'b1;
         else if (r_state == S_DONE)
            r_err <= 1'b0;
      end
   end

   // An ack in the limit cycle takes priority over the abort.
   assign w_timeout = (r_state == S_BUSY) && !bus_ack && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign err       = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0 & (TIMEOUT_CYC > 0);
`endif

   assign stall     = ((r_state == S_IDLE) & start) | (r_state == S_BUSY);
   assign done      = (r_state == S_DONE);
   assign misalign  = r_misalign;
   assign rdata_out = r_rdata;
   assign bus_req   = (r_state == S_BUSY);
   assign bus_we    = (r_state == S_BUSY) & r_is_store;
   assign bus_addr  = r_bus_addr;
   assign bus_be    = r_bus_be;
   assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_controller.sv
`default_nettype none
// tb_lsu_controller: scoreboard bench for lsu_controller; expected results are queued at issue.
module tb_lsu_controller;

`ifdef LSU_TIMEOUT_EN
   localparam int TCYC = 4;
   localparam int HOLD = 3;
`else
   localparam int TCYC = 255;
   localparam int HOLD = 1000;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] wdata_in;
   logic        stall;
   logic        done;
   logic [31:0] rdata_out;
   logic        misalign;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
      logic        mis;
      logic        err;
      logic        bus;
      int          stalls;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   lsu_controller #(.ADDR_W(32), .TIMEOUT_CYC(TCYC)) u_dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .func3(func3),
      .addr(addr), .wdata_in(wdata_in), .stall(stall), .done(done),
      .rdata_out(rdata_out), .misalign(misalign), .err(err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int waits);
      exp_t        e;
      logic [1:0]  off;
      logic [7:0]  b;
      logic [15:0] h;
      logic        tmo;
      off = a[1:0];
      b   = rd[8*off +: 8];
      h   = off[1] ? rd[31:16] : rd[15:0];
      e.addr  = a & 32'hFFFF_FFFC;
      e.we    = st;
      e.be    = 4'h0;
      e.wdata = wd;
      e.mis   = 1'b1;
      case (f3)
         3'b000, 3'b100: begin
            case (off)
               2'd0: e.be = 4'h1;
               2'd1: e.be = 4'h2;
               2'd2: e.be = 4'h4;
               default: e.be = 4'h8;
            endcase
            e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            e.mis   = st && f3[2];
         end
         3'b001, 3'b101: begin
            e.be    = off[1] ? 4'hC : 4'h3;
            e.wdata = {wd[15:0], wd[15:0]};
            e.mis   = off[0] || (st && f3[2]);
         end
         3'b010: begin
            e.be  = 4'hF;
            e.mis = (off != 2'd0);
         end
         default: e.mis = 1'b1;
      endcase
`ifdef LSU_TIMEOUT_EN
      tmo = !e.mis && (waits >= TCYC);
`else
      tmo = 1'b0;
`endif
      e.err    = tmo;
      e.bus    = !e.mis;
      e.stalls = e.mis ? 1 : (tmo ? 1 + TCYC : 2 + waits);
      if (e.mis || st || tmo) e.rdata = 32'h0;
      else begin
         case (f3)
            3'b000:  e.rdata = {{24{b[7]}}, b};
            3'b100:  e.rdata = {24'h0, b};
            3'b001:  e.rdata = {{16{h[15]}}, h};
            3'b101:  e.rdata = {16'h0, h};
            default: e.rdata = rd;
         endcase
      end
      return e;
   endfunction

   task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int waits);
      exp_t e;
      int   w;
      int   stalls;
      int   nbus;
      bit   fin;
      sbq.push_back(model(st, f3, a, wd, rd, waits));
      @(negedge clk);
      start = 1'b1; is_store = st; func3 = f3; addr = a; wdata_in = wd; bus_rdata = rd;
      w = 0; stalls = 0; nbus = 0; fin = 1'b0;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         #1;
         if (stall) stalls++;
         if (bus_req) begin
            if (nbus == 0) begin
               e = sbq[0];
               check("bus_we", bus_we, e.we);
               check("bus_addr", bus_addr, e.addr);
               check("bus_be", bus_be, e.be);
               if (e.we) check("bus_wdata", bus_wdata, e.wdata);
            end
            nbus++;
            bus_ack = (w == waits);
            w++;
         end else begin
            bus_ack = 1'b0;
         end
         if (done) begin
            e = sbq.pop_front();
            check("rdata_out", rdata_out, e.rdata);
            check("misalign", misalign, e.mis);
            check("err", err, e.err);
            check("stall_cycles", stalls, e.stalls);
            if (!e.bus) check("no_bus_cycle", nbus, 0);
            start = 1'b0;
            fin   = 1'b1;
         end
         if (!fin) @(negedge clk);
      end
      if (!fin) begin
         check("done_timeout", 0, 1);
         void'(sbq.pop_front());
         start = 1'b0;
         bus_ack = 1'b0;
      end
      @(negedge clk);
      #1;
      check("done_clear", done, 0);
      check("stall_clear", stall, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_store = 1'b0; func3 = 3'b000; addr = 32'h0;
      wdata_in = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_req", bus_req, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      check("rst_misalign", misalign, 0);
      check("rst_err", err, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_be", bus_be, 0);
      check("rst_wdata", bus_wdata, 0);
      check("rst_rdata", rdata_out, 0);
      rst = 1'b0;

      run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
      run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
      run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
      run(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0);
      run(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
      run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
      run(1'b0, 3'b001, 32'h102, 32'h0, 32'h80017F00, 1);
      run(1'b0, 3'b101, 32'h100, 32'h0, 32'h0000F00F, 0);
      run(1'b0, 3'b001, 32'h100, 32'h0, 32'h0000F00F, 2);
      run(1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1);
      run(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 0);
      run(1'b1, 3'b100, 32'h300, 32'h11, 32'h0, 0);
      run(1'b0, 3'b101, 32'h103, 32'h0, 32'h0, 0);
      run(1'b0, 3'b000, 32'h102, 32'h0, 32'h44332211, 0);
`ifdef LSU_TIMEOUT_EN
      run(1'b0, 3'b010, 32'h600, 32'h0, 32'h12345678, 100);
      run(1'b0, 3'b010, 32'h604, 32'h0, 32'h87654321, TCYC - 1);
`endif

      // Reset mid-access must drop the request without waiting for a clock edge.
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h500;
      repeat (HOLD) @(negedge clk);
      #1;
      check("hold_req", bus_req, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_req", bus_req, 0);
      check("rst_mid_done", done, 0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      check("stray_ack_done", done, 0);
      check("stray_ack_req", bus_req, 0);

      run(1'b0, 3'b010, 32'h700, 32'h0, 32'hA5A55A5A, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
